// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding,
// wait-counter width and the default memory-timeout budget.
package pipe_ctrl_pkg;

   // Encoding 3 is never entered on purpose; the FSM sends it back to RUN.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_TIMEOUT = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   localparam int unsigned CNT_W                  = 8;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard unit: resolves load-use bubbles, branch flushes and
// memory-access stalls, with a watchdog that parks the pipeline in TIMEOUT
// if a memory response never arrives.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_ex_memread_i,
   input  logic [4:0] if_id_rs1_i,
   input  logic [4:0] if_id_rs2_i,
   input  logic [4:0] id_ex_rd_i,
   input  logic       branch_taken_i,
   input  logic       mem_req_i,
   input  logic       mem_done_i,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       flushD,
   output logic       flushE,
   output logic       timeout_o,
   output logic [1:0] state_o
);

   // Last counter value before the watchdog fires (counter starts at 0).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout_q;
   logic             loaduse;
   logic             memstall;

   // Hazard detection: a load in EX whose destination feeds the instruction in ID.
   assign loaduse = id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
                    ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));

   // Memory stall holds the whole pipe until the response arrives; a response
   // in the same cycle as the request never stalls.
   assign memstall = ((state_q == ST_RUN)     && mem_req_i && !mem_done_i) ||
                     ((state_q == ST_MEMWAIT) && !mem_done_i);

   // State register, asynchronously forced back to RUN by rst.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // Next-state logic; mem_req_i is deliberately ignored while waiting.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_done_i) state_d = ST_MEMWAIT;
         end
         ST_MEMWAIT: begin
            if (mem_done_i)                   state_d = ST_RUN;
            else if (wait_cnt_q == CNT_LAST)  state_d = ST_TIMEOUT;
         end
         ST_TIMEOUT: state_d = ST_TIMEOUT;
         ST_ILLEGAL: state_d = ST_RUN;
      endcase
   end

   // Output decode in priority order: timeout/memory stall, branch, load-use.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      if (memstall || (state_q == ST_TIMEOUT)) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else if (branch_taken_i) begin
         // Any load-use seen here belongs to the wrong path and is dropped.
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (loaduse) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   // Wait counter: cleared in RUN, counts MEMWAIT cycles, frozen in TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          wait_cnt_q <= '0;
      else if (state_q == ST_MEMWAIT)   wait_cnt_q <= wait_cnt_q + 1'b1;
      else if (state_q != ST_TIMEOUT)   wait_cnt_q <= '0;
   end

   // Sticky timeout flag, raised together with entry into TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        timeout_q <= 1'b0;
      else if (state_d == ST_TIMEOUT) timeout_q <= 1'b1;
   end

   assign timeout_o = timeout_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl with a short watchdog
// (TIMEOUT_CYCLES=4). Expected outputs come from a behavioural model that
// tracks "waiting", "cycles waited" and "dead" as plain bits and integers.
module tb_pipeline_stall_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_ex_memread_i;
   logic [4:0] if_id_rs1_i;
   logic [4:0] if_id_rs2_i;
   logic [4:0] id_ex_rd_i;
   logic       branch_taken_i;
   logic       mem_req_i;
   logic       mem_done_i;
   logic       stallF, stallD, stallE, stallM, flushD, flushE, timeout_o;
   logic [1:0] state_o;

   pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_ex_memread_i (id_ex_memread_i),
      .if_id_rs1_i     (if_id_rs1_i),
      .if_id_rs2_i     (if_id_rs2_i),
      .id_ex_rd_i      (id_ex_rd_i),
      .branch_taken_i  (branch_taken_i),
      .mem_req_i       (mem_req_i),
      .mem_done_i      (mem_done_i),
      .stallF          (stallF),
      .stallD          (stallD),
      .stallE          (stallE),
      .stallM          (stallM),
      .flushD          (flushD),
      .flushE          (flushE),
      .timeout_o       (timeout_o),
      .state_o         (state_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   bit m_wait;    // a memory access is outstanding
   bit m_dead;    // watchdog fired; only reset revives
   int m_waited;  // completed cycles spent waiting

   // Observed / expected output vector:
   // {stallF,stallD,stallE,stallM,flushD,flushE,timeout_o,state_o[1:0]}
   logic [8:0] act;
   logic [8:0] exp_v;

   function automatic logic [8:0] predict();
      bit         lu;
      bit         ms;
      logic [5:0] sf;
      logic [1:0] st;
      lu = id_ex_memread_i && (id_ex_rd_i != 0) &&
           (id_ex_rd_i == if_id_rs1_i || id_ex_rd_i == if_id_rs2_i);
      ms = !m_dead && (m_wait ? !mem_done_i : (mem_req_i && !mem_done_i));
      if (m_dead || ms)        sf = 6'b111100;
      else if (branch_taken_i) sf = 6'b000011;
      else if (lu)             sf = 6'b110001;
      else                     sf = 6'b000000;
      st = m_dead ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
      return {sf, m_dead, st};
   endfunction

   task automatic model_clock();
      if (m_dead) return;
      if (m_wait) begin
         if (mem_done_i) m_wait = 1'b0;
         else if (m_waited + 1 == TO) m_dead = 1'b1;
         else m_waited++;
      end else if (mem_req_i && !mem_done_i) begin
         m_wait   = 1'b1;
         m_waited = 0;
      end
   endtask

   task automatic model_reset();
      m_wait   = 1'b0;
      m_dead   = 1'b0;
      m_waited = 0;
   endtask

   task automatic sample();
      act = {stallF, stallD, stallE, stallM, flushD, flushE, timeout_o, state_o};
   endtask

   // Apply one cycle of inputs: sample at the falling edge, advance the model
   // at the rising edge, return 1 ns after it.
   task automatic cycle(input logic mr, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic br, input logic req,
                        input logic done);
      id_ex_memread_i = mr;
      if_id_rs1_i     = rs1;
      if_id_rs2_i     = rs2;
      id_ex_rd_i      = rd;
      branch_taken_i  = br;
      mem_req_i       = req;
      mem_done_i      = done;
      @(negedge clk);
      sample();
      exp_v = predict();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      id_ex_memread_i = 1'b0;
      if_id_rs1_i     = 5'd0;
      if_id_rs2_i     = 5'd0;
      id_ex_rd_i      = 5'd0;
      branch_taken_i  = 1'b0;
      mem_req_i       = 1'b0;
      mem_done_i      = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      model_reset();
      sample();
      exp_v = predict();
      vectors++;
      if (act !== exp_v || act !== 9'b0) begin
         miscompares++;
         $display("FAIL reset got=%b want=%b", act, exp_v);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_load_use();
      logic [8:0] want [3] = '{9'b110001_0_00, 9'b0, 9'b0};
      cycle(1, 5'd3, 5'd5, 5'd5, 0, 0, 0);
      vectors++;
      if (act !== want[0]) begin
         miscompares++;
         $display("FAIL load_use_hit got=%b want=%b", act, want[0]);
      end
      cycle(0, 5'd3, 5'd5, 5'd5, 0, 0, 0);
      vectors++;
      if (act !== want[1]) begin
         miscompares++;
         $display("FAIL load_use_release got=%b want=%b", act, want[1]);
      end
      cycle(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      vectors++;
      if (act !== want[2]) begin
         miscompares++;
         $display("FAIL load_use_x0 got=%b want=%b", act, want[2]);
      end
      for (int i = 0; i < 40; i++) begin
         cycle($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 0, 0, 0);
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL load_use_rand[%0d] got=%b want=%b", i, act, exp_v);
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [1:0] st_seq [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      logic       stl_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 0, 0, 0, (i < 5), (i == 4));
         vectors++;
         if (act !== exp_v || act[1:0] !== st_seq[i] || act[8] !== stl_seq[i]) begin
            miscompares++;
            $display("FAIL mem_wait[%0d] got=%b want=%b", i, act, exp_v);
         end
      end
      // Same-cycle completion never stalls or leaves RUN.
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 0, 0, 0, 1, 1);
         vectors++;
         if (act !== exp_v || act !== 9'b0) begin
            miscompares++;
            $display("FAIL mem_same_cycle[%0d] got=%b want=%b", i, act, exp_v);
         end
      end
   endtask

   task automatic test_priority();
      cycle(1, 5'd5, 5'd7, 5'd7, 1, 0, 0);
      vectors++;
      if (act !== exp_v || act !== 9'b000011_0_00) begin
         miscompares++;
         $display("FAIL prio_branch got=%b want=%b", act, exp_v);
      end
      cycle(1, 5'd5, 5'd7, 5'd7, 1, 1, 0);
      vectors++;
      if (act !== exp_v || act !== 9'b111100_0_00) begin
         miscompares++;
         $display("FAIL prio_memstall got=%b want=%b", act, exp_v);
      end
      // Now in MEMWAIT: request ignored, done releases and branch takes over.
      cycle(1, 5'd5, 5'd7, 5'd7, 1, 0, 1);
      vectors++;
      if (act !== exp_v || act !== 9'b000011_0_01) begin
         miscompares++;
         $display("FAIL prio_done_branch got=%b want=%b", act, exp_v);
      end
   endtask

   task automatic test_timeout();
      test_reset();
      for (int i = 0; i < TO + 4; i++) begin
         cycle(0, 0, 0, 0, $urandom_range(0, 1), 1, (i > TO));
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL timeout_run[%0d] got=%b want=%b", i, act, exp_v);
         end
      end
      vectors++;
      if (state_o !== 2'd2 || timeout_o !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky got=%0d/%b want=2/1", state_o, timeout_o);
      end
      test_reset();
      // Done on the 4th MEMWAIT cycle beats the watchdog.
      for (int i = 0; i < TO + 2; i++) begin
         cycle(0, 0, 0, 0, 0, (i == 0), (i == TO));
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL timeout_edge[%0d] got=%b want=%b", i, act, exp_v);
         end
      end
      vectors++;
      if (state_o !== 2'd0 || timeout_o !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_edge_end got=%0d/%b want=0/0", state_o, timeout_o);
      end
   endtask

   task automatic test_reset_mid_wait();
      cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      mem_req_i = 1'b0;
      rst       = 1'b1;
      #2;
      model_reset();
      sample();
      exp_v = predict();
      vectors++;
      if (act !== exp_v || act !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_mid_wait got=%b want=%b", act, exp_v);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL reset_mid_wait_after got=%b want=%b", act, exp_v);
      end
   endtask

   task automatic test_random();
      int dead_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         if (dead_cycles > 3 || $urandom_range(0, 99) < 2) begin
            test_reset();
            dead_cycles = 0;
         end
         cycle($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL random[%0d] got=%b want=%b", i, act, exp_v);
         end
         if (m_dead) dead_cycles++;
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_mem_wait();
      test_priority();
      test_timeout();
      test_reset();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
